// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 definitions for the M-extension execution unit
//
// Purpose : alu_sel codes of the M extension, the mul/div FSM state encoding,
//           the datapath width and small opcode-decoding helpers.
// Ports   : none (package)
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_MUL    = 5'b01000;
  localparam logic [4:0] ALU_MULH   = 5'b01001;
  localparam logic [4:0] ALU_MULHSU = 5'b01010;
  localparam logic [4:0] ALU_MULHU  = 5'b01011;
  localparam logic [4:0] ALU_DIV    = 5'b01100;
  localparam logic [4:0] ALU_DIVU   = 5'b01101;
  localparam logic [4:0] ALU_REM    = 5'b01110;
  localparam logic [4:0] ALU_REMU   = 5'b01111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  // All eight M-ops live in the 5'b01xxx block of the alu_sel space.
  function automatic logic is_m_op(input logic [4:0] sel);
    return sel[4:3] == 2'b01;
  endfunction

  function automatic logic is_mul_op(input logic [4:0] sel);
    return sel[4:2] == 3'b010;
  endfunction

  function automatic logic is_signed_div(input logic [4:0] sel);
    return (sel == ALU_DIV) || (sel == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] sel);
    return (sel == ALU_REM) || (sel == ALU_REMU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/response bundle between ID/EX and the mul/div unit
//
// Purpose : groups the operation request, flush and result/status signals.
// Ports   : slave  - the execution unit (consumes request, drives status)
//           master - the pipeline side (drives request, observes status)
interface mul_div_unit_if;
  import rv32_pkg::*;

  logic            start_in;
  logic [4:0]      alu_sel_in;
  logic [XLEN-1:0] operand1_in;
  logic [XLEN-1:0] operand2_in;
  logic            flush_in;
  logic [XLEN-1:0] result_out;
  logic            done_out;
  logic            busy_out;
  logic            stall_out;

  modport slave (
    input  start_in, alu_sel_in, operand1_in, operand2_in, flush_in,
    output result_out, done_out, busy_out, stall_out
  );

  modport master (
    output start_in, alu_sel_in, operand1_in, operand2_in, flush_in,
    input  result_out, done_out, busy_out, stall_out
  );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
//
// Purpose : shifts {rem,quo} left by one, trial-subtracts the divisor from the
//           widened partial remainder and keeps the difference when it does
//           not borrow, shifting the resulting quotient bit into quo.
// Ports   : i_rem/i_quo   - current partial remainder / dividend-quotient shift reg
//           i_divisor     - divisor magnitude
//           o_rem/o_quo   - values after this step
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  // One extra bit: with an unsigned divisor near 2^W the shifted remainder
  // can exceed W bits before the subtract brings it back below the divisor.
  logic [W:0] w_shifted;
  logic [W:0] w_diff;
  logic       w_fits;
  logic       w_unused;

  assign w_shifted = {i_rem, i_quo[W-1]};
  assign w_fits    = w_shifted >= {1'b0, i_divisor};
  assign w_diff    = w_shifted - {1'b0, i_divisor};

  // The kept remainder is always below the divisor, so the top bit is zero.
  assign o_rem    = w_fits ? w_diff[W-1:0] : w_shifted[W-1:0];
  assign o_quo    = {i_quo[W-2:0], w_fits};
  assign w_unused = w_diff[W];

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle RV32M multiply/divide unit for the EX stage
//
// Purpose : single-cycle registered multiplies, 32-step restoring divides with
//           a sign-fixup cycle, and divide-by-zero / overflow short cuts.
// Ports   : clk   - clock
//           reset - asynchronous, active-high reset
//           bus   - request (start/alu_sel/operands/flush) and response
//                   (result/done/busy/stall), see mul_div_unit_if
module mul_div_unit #(
  parameter int XLEN      = rv32_pkg::XLEN,
  parameter int DIV_STEPS = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  import rv32_pkg::*;

  localparam int CW = $clog2(DIV_STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_STEPS - 1);

  mdu_state_t      r_state;
  mdu_state_t      w_next_state;

  logic [4:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [CW-1:0]   r_count;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_is_mul;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_special;
  logic            w_op1_neg;
  logic            w_op2_neg;
  logic [XLEN-1:0] w_op1_mag;
  logic [XLEN-1:0] w_op2_mag;
  logic [XLEN-1:0] w_sp_quo;
  logic [XLEN-1:0] w_sp_rem;
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_step_quo;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_b_ext;
  logic [2*XLEN-1:0] w_product;
  logic [XLEN-1:0] w_mul_result;
  logic [XLEN-1:0] w_fix_quo;
  logic [XLEN-1:0] w_fix_rem;
  logic [XLEN-1:0] w_fix_result;

  // ---------------------------------------------------------------- accept
  assign w_accept = bus.start_in & is_m_op(bus.alu_sel_in) & ~bus.flush_in &
                    ((r_state == ST_IDLE) || (r_state == ST_DONE));

  assign w_is_mul   = is_mul_op(bus.alu_sel_in);
  assign w_div_zero = (bus.operand2_in == '0);
  assign w_overflow = is_signed_div(bus.alu_sel_in) &
                      (bus.operand1_in == {1'b1, {(XLEN-1){1'b0}}}) &
                      (bus.operand2_in == '1);
  assign w_special  = ~w_is_mul & (w_div_zero | w_overflow);

  assign w_op1_neg = is_signed_div(bus.alu_sel_in) & bus.operand1_in[XLEN-1];
  assign w_op2_neg = is_signed_div(bus.alu_sel_in) & bus.operand2_in[XLEN-1];
  assign w_op1_mag = w_op1_neg ? (~bus.operand1_in + 1'b1) : bus.operand1_in;
  assign w_op2_mag = w_op2_neg ? (~bus.operand2_in + 1'b1) : bus.operand2_in;

  // Special cases park their final answer in quo/rem with clear sign flags,
  // so the FIX cycle just selects it like any other divide result.
  assign w_sp_quo = w_div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
  assign w_sp_rem = w_div_zero ? bus.operand1_in : '0;

  // -------------------------------------------------------------- multiply
  assign w_a_sgn      = (r_op != ALU_MULHU);
  assign w_b_sgn      = (r_op == ALU_MUL) || (r_op == ALU_MULH);
  assign w_a_ext      = {{XLEN{w_a_sgn & r_a[XLEN-1]}}, r_a};
  assign w_b_ext      = {{XLEN{w_b_sgn & r_b[XLEN-1]}}, r_b};
  assign w_product    = w_a_ext * w_b_ext;
  assign w_mul_result = (r_op == ALU_MUL) ? w_product[XLEN-1:0]
                                          : w_product[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------- divide
  div_step #(.W(XLEN)) u_div_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  assign w_fix_quo    = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_fix_rem    = r_neg_r ? (~r_rem + 1'b1) : r_rem;
  assign w_fix_result = is_rem_op(r_op) ? w_fix_rem : w_fix_quo;

  // ------------------------------------------------------ FSM: state reg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ----------------------------------------------------- FSM: next state
  always_comb begin
    w_next_state = r_state;
    if (bus.flush_in) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (!w_accept)      w_next_state = ST_IDLE;
          else if (w_is_mul)  w_next_state = ST_MUL;
          else if (w_special) w_next_state = ST_FIX;
          else                w_next_state = ST_DIV;
        end
        ST_MUL:  w_next_state = ST_DONE;
        ST_DIV:  if (r_count == LAST_STEP) w_next_state = ST_FIX;
        ST_FIX:  w_next_state = ST_DONE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------- FSM: outputs
  always_comb begin
    bus.busy_out   = (r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIX);
    bus.done_out   = (r_state == ST_DONE);
    bus.stall_out  = w_accept | bus.busy_out;
    bus.result_out = r_result;
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_count <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_op    <= bus.alu_sel_in;
      r_a     <= bus.operand1_in;
      r_b     <= bus.operand2_in;
      r_count <= '0;
      if (w_is_mul) begin
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_special) begin
        r_quo   <= w_sp_quo;
        r_rem   <= w_sp_rem;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_quo   <= w_op1_mag;
        r_rem   <= '0;
        r_div   <= w_op2_mag;
        r_neg_q <= w_op1_neg ^ w_op2_neg;
        r_neg_r <= w_op1_neg;
      end
    end else if (r_state == ST_DIV) begin
      r_rem   <= w_step_rem;
      r_quo   <= w_step_quo;
      r_count <= r_count + CW'(1);
    end
  end

  // result_out only moves on the edge that enters DONE; a flush blocks it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
    end else if (!bus.flush_in) begin
      if (r_state == ST_MUL)      r_result <= w_mul_result;
      else if (r_state == ST_FIX) r_result <= w_fix_result;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;
  import rv32_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_exp = '0;
  exp_t exp_q[$];

  mul_div_unit_if bus ();

  mul_div_unit #(.XLEN(32), .DIV_STEPS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference behaviour, straight from the RV32M arithmetic rules.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      ALU_MUL:    begin p = sa * sb; return p[31:0]; end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      ALU_MULHU:  begin up = ua * ub; return up[63:32]; end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      ALU_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  // Edges from the accept edge until the edge that enters DONE.
  function automatic int latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] == 1'b0) return 1;
    if (b == 0) return 1;
    if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=%h want=none (cycle %0d)", bus.result_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", bus.result_out, e.res);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        last_exp = e.res;
      end
    end
  end

  // Waits for a free unit, presents one request and returns at accept edge + 2.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
    int   guard;
    exp_t e;
    guard = 0;
    while (bus.busy_out && guard < 200) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 200) check("wait_not_busy", 32'(bus.busy_out), 32'd0);
    bus.start_in    = 1'b1;
    bus.alu_sel_in  = op;
    bus.operand1_in = a;
    bus.operand2_in = b;
    @(posedge clk); #1;
    if (track) begin
      e.res = model(op, a, b);
      e.cyc = cyc + latency(op, a, b);
      exp_q.push_back(e);
    end
    bus.start_in   = 1'b0;
    bus.alu_sel_in = 5'b00000;
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #2;
  endtask

  // Counts cycles with sig high, sampled once per cycle from the current point.
  task automatic count_high(input bit use_busy, output int n);
    n = 0;
    while ((use_busy ? bus.busy_out : bus.stall_out) && n < 100) begin
      n++;
      @(posedge clk); #2;
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    bus.start_in    = 1'b0;
    bus.alu_sel_in  = 5'b00000;
    bus.operand1_in = '0;
    bus.operand2_in = '0;
    bus.flush_in    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_result", bus.result_out, 32'h0);
    check("reset_done", 32'(bus.done_out), 32'd0);
    check("reset_busy", 32'(bus.busy_out), 32'd0);
    check("reset_stall", 32'(bus.stall_out), 32'd0);
    reset = 1'b0;
    @(posedge clk); #2;

    // MULH most-negative squared; stall covers only the MUL cycle after accept.
    issue(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 1'b1);
    count_high(1'b0, n);
    check("mulh_stall_cycles", 32'(n), 32'd1);
    drain();

    issue(ALU_DIVU, 32'd100, 32'd7, 1'b1);
    count_high(1'b1, n);
    check("divu_busy_cycles", 32'(n), 32'd33);
    issue(ALU_REMU, 32'd100, 32'd7, 1'b1);
    issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(ALU_REM, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(ALU_DIV, 32'd5, 32'd0, 1'b1);
    issue(ALU_REMU, 32'd5, 32'd0, 1'b1);
    drain();

    // A non-M op is ignored.
    bus.start_in   = 1'b1;
    bus.alu_sel_in = 5'b00000;
    #1;
    check("non_m_stall", 32'(bus.stall_out), 32'd0);
    @(posedge clk); #2;
    check("non_m_busy", 32'(bus.busy_out), 32'd0);
    bus.start_in = 1'b0;

    // Flush at divider count 10.
    issue(ALU_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1 bus.flush_in = 1'b1;
    @(posedge clk); #1;
    bus.flush_in = 1'b0;
    #1;
    check("flush_busy", 32'(bus.busy_out), 32'd0);
    check("flush_done", 32'(bus.done_out), 32'd0);
    check("flush_result_held", bus.result_out, last_exp);
    repeat (40) @(posedge clk);
    #2;

    // Reset at divider count 20.
    issue(ALU_DIVU, 32'hDEAD_BEEF, 32'd13, 1'b0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_result", bus.result_out, 32'h0);
    check("rst_mid_done", 32'(bus.done_out), 32'd0);
    check("rst_mid_busy", 32'(bus.busy_out), 32'd0);
    check("rst_mid_stall", 32'(bus.stall_out), 32'd0);
    last_exp = '0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #2;

    // Back-to-back: DIVU accepted in the MUL's DONE cycle.
    issue(ALU_MUL, 32'd3, 32'd4, 1'b1);
    @(posedge clk); #2;
    check("b2b_done_in_done", 32'(bus.done_out), 32'd1);
    check("b2b_stall_no_start", 32'(bus.stall_out), 32'd0);
    issue(ALU_DIVU, 32'd9, 32'd3, 1'b1);
    drain();

    for (int i = 0; i < 150; i++) begin
      issue(5'b01000 + 5'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
